// File: rtl/tx_framer.sv
// Frames a 32-bit ciphertext stream as: header {sync, seq}, C_PAYLOAD_WORDS payload words, XOR-checksum trailer (tlast).
// Latency: one cycle from input transfer to m_axis; the header appears one cycle after a frame starts.
// Backpressure: single output register; s_axis_tready is low while the output register is full and not draining.
module tx_framer #(
  parameter int          C_PAYLOAD_WORDS = 16,
  parameter logic [15:0] C_SYNC_PATTERN  = 16'hA5C3
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        i_enable,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [31:0] o_frame_count,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  localparam logic [8:0] LAST_IDX = 9'(C_PAYLOAD_WORDS - 1);

  state_t      state_q, state_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] chk_q, chk_d;
  logic [8:0]  wcnt_q, wcnt_d;

  // The output register may take a new word when it is empty or being drained this cycle.
  logic load_ok;
  logic s_xfer;

  assign load_ok       = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == PAYLOAD) && load_ok;
  assign s_xfer        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign o_frame_count = frame_cnt_q;
  assign o_busy        = (state_q != IDLE);

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
      seq_q       <= '0;
      chk_q       <= '0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // Next-state and output-register loading for each framing phase.
  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    frame_cnt_d = frame_cnt_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    wcnt_d      = wcnt_q;

    case (state_q)
      IDLE: begin
        // Input valid only gates the start; the first payload word is consumed in PAYLOAD.
        if (i_enable && s_axis_tvalid) begin
          state_d = HEADER;
          chk_d   = '0;
          wcnt_d  = '0;
        end
      end

      HEADER: begin
        if (load_ok) begin
          tvalid_d = 1'b1;
          tdata_d  = {C_SYNC_PATTERN, seq_q};
          tlast_d  = 1'b0;
          chk_d    = chk_q ^ {C_SYNC_PATTERN, seq_q};
          state_d  = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (s_xfer) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          tlast_d  = 1'b0;
          chk_d    = chk_q ^ s_axis_tdata;
          wcnt_d   = wcnt_q + 9'd1;
          if (wcnt_q == LAST_IDX) begin
            state_d = TRAILER;
          end
        end else if (load_ok) begin
          // Input stalled: let the register empty rather than emit a bubble word.
          tvalid_d = 1'b0;
        end
      end

      TRAILER: begin
        // tlast_q distinguishes "trailer still to load" from "trailer waiting to transfer".
        if (!tlast_q) begin
          if (load_ok) begin
            tvalid_d = 1'b1;
            tdata_d  = chk_q;
            tlast_d  = 1'b1;
          end
        end else if (m_axis_tready) begin
          tvalid_d    = 1'b0;
          tlast_d     = 1'b0;
          frame_cnt_d = frame_cnt_q + 32'd1;
          seq_d       = seq_q + 16'd1;
          chk_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_framer.sv
// Randomized bench for tx_framer with a frame-level reference model and an output scoreboard.
// Each scenario task drives stimulus and compares collected output words against the model.
// m_axis_tready is driven per a mode variable: always-high, toggling, or random.
module tb_tx_framer;

  localparam int N = 4;

  logic        s_axi_aclk;
  logic        s_axi_aresetn;
  logic        i_enable;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [31:0] o_frame_count;
  logic        o_busy;

  tx_framer #(.C_PAYLOAD_WORDS(N), .C_SYNC_PATTERN(16'hA5C3)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .i_enable      (i_enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .o_frame_count (o_frame_count),
    .o_busy        (o_busy)
  );

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;              // 0: always 1, 1: toggle, 2: random

  logic [15:0] seq_model = 16'h0;
  logic [31:0] frames_model = 32'h0;
  logic [31:0] pay_q[$];
  logic [32:0] exp_q[$];         // {tlast, data}
  logic [32:0] got_q[$];

  initial s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  // Output-side ready pattern, updated just after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge s_axi_aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Collect every output transfer; inputs are stable around the falling edge.
  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn && m_axis_tvalid && m_axis_tready)
      got_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  // Reference model: a whole frame from the current payload list.
  task automatic model_frame();
    logic [31:0] hdr;
    logic [31:0] x;
    hdr = {16'hA5C3, seq_model};
    x = hdr;
    exp_q.push_back({1'b0, hdr});
    foreach (pay_q[i]) begin
      exp_q.push_back({1'b0, pay_q[i]});
      x = x ^ pay_q[i];
    end
    exp_q.push_back({1'b1, x});
    seq_model = seq_model + 16'd1;
    frames_model = frames_model + 32'd1;
  endtask

  // Present one word and hold it until the DUT accepts it (bounded).
  task automatic send_word(input logic [31:0] d);
    bit acc;
    acc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge s_axi_aclk);
      if (s_axis_tready) acc = 1;
      @(posedge s_axi_aclk);
      #1;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_word timeout: word %08h not accepted within 300 cycles", d);
    end
  endtask

  // Send pay_q, optionally with random valid gaps, and drop valid afterwards.
  task automatic drive_payload(input bit gaps);
    foreach (pay_q[i]) begin
      send_word(pay_q[i]);
      if (gaps && i != pay_q.size() - 1) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge s_axi_aclk);
        #1;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic fill_random();
    pay_q.delete();
    for (int i = 0; i < N; i++) pay_q.push_back($urandom);
  endtask

  // Wait for the expected words, then compare word-by-word plus frame count.
  task automatic check_output(input string name);
    int budget;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 1000) begin
      @(posedge s_axi_aclk);
      budget++;
    end
    repeat (4) @(posedge s_axi_aclk);
    #1;
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s word_count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s word[%0d]: got tlast=%0b data=%08h, expected tlast=%0b data=%08h",
                   name, i, got_q[i][32], got_q[i][31:0], exp_q[i][32], exp_q[i][31:0]);
        end
      end
    end
    tests++;
    if (o_frame_count !== frames_model) begin
      fails++;
      $display("FAIL %s frame_count: got %0d, expected %0d", name, o_frame_count, frames_model);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, o_busy, o_frame_count} !== 67'h0) begin
      fails++;
      $display("FAIL %s: tvalid=%0b tdata=%08h tlast=%0b s_tready=%0b busy=%0b count=%0d, expected all zero",
               name, m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, o_busy, o_frame_count);
    end
  endtask

  task automatic test_reset();
    s_axi_aresetn = 1'b0;
    i_enable = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    #1;
    check_zero_outputs("reset_state");
    repeat (3) @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    i_enable = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    check_zero_outputs("after_release");
  endtask

  task automatic test_single_frame();
    rdy_mode = 0;
    pay_q.delete();
    for (int i = 1; i <= N; i++) pay_q.push_back(32'(i));
    model_frame();
    tests++;
    if (exp_q[N + 1] !== {1'b1, 32'hA5C30004}) begin
      fails++;
      $display("FAIL single_trailer_model: got %09h, expected %09h", exp_q[N + 1], {1'b1, 32'hA5C30004});
    end
    drive_payload(0);
    check_output("single_frame");
  endtask

  task automatic test_backpressure();
    rdy_mode = 1;
    pay_q.delete();
    for (int i = 1; i <= N; i++) pay_q.push_back(32'(i));
    model_frame();
    drive_payload(0);
    check_output("backpressure_toggle");
    rdy_mode = 0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      rdy_mode = 2;
      fill_random();
      model_frame();
      drive_payload(1);
      check_output("random_frame");
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[$];
    int busy_cnt, idle_cnt, tv_cnt, w;
    rdy_mode = 0;
    words.delete();
    for (int f = 0; f < 2; f++) begin
      fill_random();
      model_frame();
      foreach (pay_q[i]) words.push_back(pay_q[i]);
    end
    busy_cnt = 0; idle_cnt = 0; tv_cnt = 0; w = 0;
    fork
      begin
        foreach (words[i]) send_word(words[i]);
        s_axis_tvalid = 1'b0;
      end
      begin
        @(negedge s_axi_aclk);
        while (!o_busy && w < 100) begin @(negedge s_axi_aclk); w++; end
        while (o_busy && busy_cnt < 100) begin
          busy_cnt++;
          if (m_axis_tvalid) tv_cnt++;
          @(negedge s_axi_aclk);
        end
        while (!o_busy && idle_cnt < 50) begin idle_cnt++; @(negedge s_axi_aclk); end
      end
    join
    tests++;
    if (busy_cnt !== N + 3) begin
      fails++;
      $display("FAIL b2b_busy_cycles: got %0d, expected %0d", busy_cnt, N + 3);
    end
    tests++;
    if (tv_cnt !== N + 2) begin
      fails++;
      $display("FAIL b2b_valid_cycles: got %0d, expected %0d", tv_cnt, N + 2);
    end
    tests++;
    if (idle_cnt !== 1) begin
      fails++;
      $display("FAIL b2b_idle_gap: got %0d, expected 1", idle_cnt);
    end
    check_output("back_to_back");
  endtask

  task automatic test_input_stall();
    int bad_rdy, bad_vld;
    rdy_mode = 0;
    fill_random();
    model_frame();
    send_word(pay_q[0]);
    send_word(pay_q[1]);
    s_axis_tvalid = 1'b0;
    bad_rdy = 0; bad_vld = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge s_axi_aclk);
      if (s_axis_tready !== 1'b1) bad_rdy++;
      if (c > 0 && m_axis_tvalid !== 1'b0) bad_vld++;
      @(posedge s_axi_aclk);
      #1;
    end
    tests++;
    if (bad_rdy !== 0) begin
      fails++;
      $display("FAIL stall_tready: tready low in %0d stall cycles, expected 0", bad_rdy);
    end
    tests++;
    if (bad_vld !== 0) begin
      fails++;
      $display("FAIL stall_no_bubble: tvalid high in %0d stall cycles, expected 0", bad_vld);
    end
    send_word(pay_q[2]);
    send_word(pay_q[3]);
    s_axis_tvalid = 1'b0;
    check_output("input_stall");
  endtask

  task automatic test_enable_drop();
    int bad;
    rdy_mode = 0;
    fill_random();
    model_frame();
    send_word(pay_q[0]);
    send_word(pay_q[1]);
    i_enable = 1'b0;
    send_word(pay_q[2]);
    send_word(pay_q[3]);
    check_output("enable_drop_frame");
    s_axis_tvalid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge s_axi_aclk);
      if (o_busy !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL enable_drop_idle: busy/valid seen in %0d cycles, expected 0", bad);
    end
    @(posedge s_axi_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    i_enable = 1'b1;
  endtask

  task automatic test_seq_wrap();
    rdy_mode = 0;
    @(negedge s_axi_aclk);
    force dut.seq_q = 16'hFFFF;
    @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    release dut.seq_q;
    @(posedge s_axi_aclk);
    #1;
    seq_model = 16'hFFFF;
    for (int f = 0; f < 2; f++) begin
      fill_random();
      model_frame();
      drive_payload(0);
    end
    tests++;
    if (exp_q[0][31:0] !== 32'hA5C3FFFF || exp_q[N + 2][31:0] !== 32'hA5C30000) begin
      fails++;
      $display("FAIL wrap_model_headers: got %08h %08h, expected A5C3FFFF A5C30000",
               exp_q[0][31:0], exp_q[N + 2][31:0]);
    end
    check_output("seq_wrap");
  endtask

  task automatic test_reset_mid_frame();
    rdy_mode = 0;
    fill_random();
    send_word(pay_q[0]);
    send_word(pay_q[1]);
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check_zero_outputs("reset_mid_frame");
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    got_q.delete();
    exp_q.delete();
    seq_model = 16'h0;
    frames_model = 32'h0;
    s_axi_aresetn = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    fill_random();
    model_frame();
    drive_payload(0);
    tests++;
    if (got_q.size() == 0 || got_q[0][31:0] !== 32'hA5C30000) begin
      fails++;
      $display("FAIL reset_next_header: got %08h (size %0d), expected A5C30000",
               (got_q.size() > 0) ? got_q[0][31:0] : 32'h0, got_q.size());
    end
    check_output("after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_input_stall();
    test_enable_drop();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 The block SHALL have parameter C_PAYLOAD_WORDS, default 16, meaning the number of payload words per frame (legal 1..256).
REQ-002 The block SHALL have parameter C_SYNC_PATTERN, default 16'hA5C3, meaning the upper 16 bits of every header word.
REQ-003 The block SHALL have port s_axi_aclk, input, 1 bit: clock for all logic.
REQ-004 The block SHALL have port s_axi_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_enable, input, 1 bit: permits new frames to start.
REQ-006 The block SHALL have port s_axis_tvalid, input, 1 bit: valid for the ciphertext stream.
REQ-007 The block SHALL have port s_axis_tready, output, 1 bit: ready for the ciphertext stream.
REQ-008 The block SHALL have port s_axis_tdata, input, 32 bits: ciphertext word.
REQ-009 The block SHALL have port m_axis_tvalid, output, 1 bit: valid for the framed stream.
REQ-010 The block SHALL have port m_axis_tready, input, 1 bit: ready for the framed stream.
REQ-011 The block SHALL have port m_axis_tdata, output, 32 bits: framed word.
REQ-012 The block SHALL have port m_axis_tlast, output, 1 bit: marks the trailer word.
REQ-013 The block SHALL have port o_frame_count, output, 32 bits: count of completed frames.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, HEADER, PAYLOAD and TRAILER.
REQ-016 In IDLE with i_enable=1 and s_axis_tvalid=1, the FSM SHALL move to HEADER; otherwise it SHALL remain in IDLE.
REQ-017 A transfer SHALL occur when valid and ready are both high on the same rising edge.
REQ-018 m_axis SHALL be a single output register; once m_axis_tvalid is high, m_axis_tdata and m_axis_tlast SHALL hold until a transfer occurs.
REQ-019 The register SHALL load a new word when m_axis_tvalid=0 or m_axis_tready=1.
REQ-020 HEADER SHALL load {C_SYNC_PATTERN, seq[15:0]} with tlast=0, then go to PAYLOAD.
REQ-021 The header SHALL appear on m_axis one cycle after the IDLE->HEADER edge.
REQ-022 s_axis_tready SHALL equal (state==PAYLOAD) && (!m_axis_tvalid || m_axis_tready), combinationally.
REQ-023 Each PAYLOAD input transfer SHALL load s_axis_tdata unmodified with tlast=0, increment the word counter, and update chk <= chk ^ s_axis_tdata.
REQ-024 After word C_PAYLOAD_WORDS is accepted, the FSM SHALL go to TRAILER.
REQ-025 TRAILER SHALL load chk with tlast=1, and the FSM SHALL wait in TRAILER until that word transfers.
REQ-026 On the trailer transfer: o_frame_count SHALL +1 (wrapping at 2^32), seq SHALL +1 (16-bit, 0xFFFF->0x0000), chk SHALL be set to 0, and the FSM SHALL go to IDLE.
REQ-027 chk SHALL be 32 bits, cleared at HEADER entry, and SHALL be the XOR of the header word and all payload words.
REQ-028 The word counter SHALL be 9 bits, cleared at HEADER entry.
REQ-029 i_enable falling mid-frame SHALL NOT abort the frame; the frame SHALL complete, and no new frame SHALL start while i_enable=0.
REQ-030 s_axis_tvalid low mid-payload SHALL stall the FSM in PAYLOAD with no bubble words emitted; m_axis_tvalid SHALL drop after the last word drains.
REQ-031 m_axis_tready low SHALL back-pressure via s_axis_tready=0, and no input word SHALL be lost or duplicated.
REQ-032 With m_axis_tready held high and s_axis_tvalid continuously high, throughput SHALL be one word per cycle: a frame of C_PAYLOAD_WORDS+2 words SHALL be followed by one IDLE cycle.

Reset
REQ-033 Asserting s_axi_aresetn low, asynchronously and at any time including mid-frame, SHALL immediately set: state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, o_busy=0, o_frame_count=0, seq=0, chk=0, word counter=0.
REQ-034 A partial frame in progress at reset SHALL be discarded and never resumed.

Verification
REQ-035 Single frame: C_PAYLOAD_WORDS=4, payload 1,2,3,4, m_axis_tready=1 -> bench observes A5C30000, 1, 2, 3, 4, trailer A5C30000^4=A5C30004 with tlast only on the trailer, and o_frame_count=1.
REQ-036 Back-pressure: m_axis_tready toggles 1/0 every cycle during a frame -> output words are identical to the single-frame case, with no drops or duplicates.
REQ-037 Seq wrap: force 65536 frames or preload seq=0xFFFF -> headers are A5C3FFFF then A5C30000.
REQ-038 Enable drop: i_enable goes to 0 after payload word 2 -> frame completes with trailer, then o_busy=0 and no further header despite s_axis_tvalid=1.
REQ-039 Reset mid-frame: assert reset after payload word 2 -> all outputs go to 0 immediately; after release the next header is A5C30000.
REQ-040 Input stall: s_axis_tvalid goes low for 5 cycles mid-payload -> s_axis_tready stays high, no extra words are emitted, and the trailer is correct.
